// File: rtl/alu_seq_if.sv
// Operation issue/result bundle between the execute stage and alu_seq.
// The master drives Start/ALUctl/A/B. The slave returns Busy/Done and the registered result flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             Overflow;

  modport master (
    output Start, ALUctl, A, B,
    input  Busy, Done, ALUOut, Zero, Overflow
  );

  modport slave (
    input  Start, ALUctl, A, B,
    output Busy, Done, ALUOut, Zero, Overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle logic/arith/shift ops, WIDTH+1-cycle iterative MUL/DIVU/REMU.
// Latency is 1 or WIDTH+1. Start is ignored while Busy, so the caller must stall; results hold until the next Done.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clock,
  input  logic        reset,
  alu_seq_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL accumulator / partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand / dividend shifting into quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier / divisor
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a, b, sum, diff, sc_res;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, is_multi;

  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = bus.B[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;
  assign is_multi = (bus.ALUctl == 4'd9) || (bus.ALUctl == 4'd10) || (bus.ALUctl == 4'd11);

  always_comb begin
    sc_res = b;
    sc_ovf = 1'b0;
    case (bus.ALUctl)
      4'd0:  sc_res = a & b;
      4'd1:  sc_res = a | b;
      4'd2: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3:  sc_res = a ^ b;
      4'd4:  sc_res = a << shamt;
      4'd5:  sc_res = a >> shamt;
      4'd6: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7:  sc_res = WIDTH'(a < b);
      4'd8:  sc_res = WIDTH'($signed(a) >>> shamt);
      4'd12: sc_res = ~(a | b);
      default: sc_res = b;
    endcase
  end

  // One iteration step of each algorithm; the final step feeds the result directly.
  logic [WIDTH-1:0] mul_nxt, div_rem_nxt, div_quo_nxt, mc_res;
  logic [WIDTH:0]   div_trial, div_sub;
  logic             div_bit;

  assign mul_nxt     = acc_q + (opb_q[0] ? opa_q : '0);
  assign div_trial   = {acc_q, opa_q[WIDTH-1]};
  assign div_sub     = div_trial - {1'b0, opb_q};
  assign div_bit     = (div_trial >= {1'b0, opb_q});
  assign div_rem_nxt = div_bit ? div_sub[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_quo_nxt = {opa_q[WIDTH-2:0], div_bit};

  always_comb begin
    case (kind_q)
      K_MUL:   mc_res = mul_nxt;
      K_DIVU:  mc_res = div_quo_nxt;
      default: mc_res = div_rem_nxt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (is_multi) begin
            state_d = S_RUN;
            cnt_d   = '0;
            acc_d   = '0;
            opa_d   = a;
            opb_d   = b;
            case (bus.ALUctl)
              4'd9:    kind_d = K_MUL;
              4'd10:   kind_d = K_DIVU;
              default: kind_d = K_REMU;
            endcase
          end else begin
            out_d  = sc_res;
            zero_d = (sc_res == '0);
            ovf_d  = sc_ovf;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (kind_q == K_MUL) begin
          acc_d = mul_nxt;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = div_rem_nxt;
          opa_d = div_quo_nxt;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          out_d   = mc_res;
          zero_d  = (mc_res == '0);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy     = (state_q == S_RUN);
  assign bus.Done     = done_q;
  assign bus.ALUOut   = out_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the pipeline's execute stage and the multi-cycle datapath. It supports the existing single-cycle opcode set (AND/OR/ADD/SUB/SLT/pass-B) and adds XOR, NOR, shifts, signed overflow detection, and iterative multiply and divide. All results are registered. A Start/Busy/Done handshake lets the hazard unit stall the pipeline while a multi-cycle operation runs.

## Interface
Parameters:
- WIDTH, 32: operand and result width; must be ≥ 4.
- SHW, $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0].

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  issue the operation on ALUctl/A/B; accepted only when Busy=0.
- ALUctl  in  4  opcode; sampled only on an accepted Start.
- A  in  WIDTH  operand A; sampled only on an accepted Start.
- B  in  WIDTH  operand B; sampled only on an accepted Start.
- Busy  out  1  a multi-cycle operation is in progress.
- Done  out  1  one-cycle pulse: ALUOut/Zero/Overflow are updated this cycle.
- ALUOut  out  WIDTH  registered result; holds between operations.
- Zero  out  1  registered; always equals (ALUOut==0).
- Overflow  out  1  registered signed overflow for ADD/SUB; 0 for all other opcodes.

## Operation
Opcodes (ALUctl):
- 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLTU (unsigned A<B → 1 else 0), 8 SRA, 12 NOR.
- 9 MUL (low WIDTH bits of A*B), 10 DIVU (unsigned quotient), 11 REMU (unsigned remainder).
- 13–15: pass B (load/store address path).

Arithmetic rules:
- ADD/SUB wrap modulo 2^WIDTH.
- ADD Overflow = operands have the same sign and the result sign differs.
- SUB Overflow = operands have different signs and the result sign differs from A.
- Shifts use B[SHW-1:0] only; upper bits of B are ignored. SRA replicates A[WIDTH-1].
- MUL: shift-add, one bit of B per cycle, WIDTH iterations. Result is identical for signed and unsigned operands (low half only).
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations.
- Divide by zero: DIVU → all ones; REMU → A. Still takes the full latency; no exception.

State machine:
- IDLE: Busy=0.
  - Start with single-cycle opcode: result registered at the next edge, Done=1, remain in IDLE.
  - Start with opcode 9/10/11: operands latched, iteration counter cleared, go to RUN.
- RUN: Busy=1. Counter increments each cycle.
  - On the cycle the counter reaches WIDTH-1: result loads into ALUOut, Done=1, return to IDLE.
  - Start is ignored in RUN (no queuing). ALUctl/A/B may change freely without affecting the operation.
- ALUOut, Zero and Overflow change only on a Done cycle or on reset.

Reset:
- ALUOut=0, Zero=1, Overflow=0, Busy=0, Done=0, state IDLE, counter 0.
- Reset asserted mid-RUN aborts the operation. No Done is produced and ALUOut is cleared.
- Reset has priority over a simultaneous Start.

## Timing
- Single-cycle ops: Start sampled at edge N → Done=1 and result visible after edge N+1 (latency 1). Back-to-back Start every cycle gives one result per cycle.
- Multi-cycle ops: Start sampled at edge N → Busy=1 after edge N+1 through edge N+WIDTH. After edge N+WIDTH+1: Busy=0, Done=1, result visible (latency WIDTH+1 = 33 for WIDTH=32).
- Done is never high for two consecutive cycles from a single Start.
- Done and Busy are never both 1.
- Start in the same cycle Done is high is accepted, because Busy=0 then.

## Test plan
- Reset then idle (WIDTH=32) → ALUOut=0, Zero=1, Overflow=0, Busy=0, Done=0.
- ADD A=0x7FFFFFFF, B=1 → next cycle ALUOut=0x80000000, Overflow=1, Done pulse.
  - SUB A=5, B=5 → ALUOut=0, Zero=1, Overflow=0.
  - SLTU A=1, B=0xFFFFFFFF → ALUOut=1.
- Shifts: SRA A=0x80000000, B=0x24 (shift 4) → 0xF8000000. SLL A=1, B=31 → 0x80000000. NOR A=0, B=0 → 0xFFFFFFFF.
- MUL A=0xFFFFFFFF, B=3 → Busy 32 cycles, Done at cycle 33, ALUOut=0xFFFFFFFD.
  - Start pulses while Busy → ignored; exactly one Done.
- DIVU A=100, B=7 → 14; REMU A=100, B=7 → 2. DIVU A=9, B=0 → 0xFFFFFFFF; REMU A=9, B=0 → 9.
- MUL issued, reset at cycle 10 of RUN → Busy=0, no Done, ALUOut=0.
  - A new ADD 2+3 immediately after reset deasserts → 5 after one cycle.
